// File: rtl/ex_mem_stage_if.sv
// Data-memory bus between the EX/MEM stage (master) and the memory controller (slave).
// Carries the request and address lines one way, and the hit and read data back.
interface ex_mem_stage_if #(
    parameter int unsigned WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN,
        output dmemWEN,
        output dmemaddr,
        output dmemstore,
        input  dhit,
        input  dmemload
    );

    modport slave (
        input  dmemREN,
        input  dmemWEN,
        input  dmemaddr,
        input  dmemstore,
        output dhit,
        output dmemload
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a data-memory access controller.
// It holds one load or store on the dmem bus until dhit and stalls the pipeline meanwhile.
module ex_mem_stage #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              flush,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] npc_in,
    input  logic [WORD_W-1:0] alu_in,
    input  logic [WORD_W-1:0] store_in,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic [REG_W-1:0]  regdst_in,
    input  logic              regwen_in,
    input  logic              memtoreg_in,
    input  logic              halt_in,
    ex_mem_stage_if.master    dbus,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] npc_out,
    output logic [WORD_W-1:0] alu_out,
    output logic [WORD_W-1:0] dmemload_out,
    output logic [REG_W-1:0]  regdst_out,
    output logic              regwen_out,
    output logic              memtoreg_out,
    output logic              halt_out,
    output logic              mem_stall
);
    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] npc_q, npc_d;
    logic [WORD_W-1:0] alu_q, alu_d;
    logic [WORD_W-1:0] store_q, store_d;
    logic [WORD_W-1:0] load_q, load_d;
    logic [REG_W-1:0]  regdst_q, regdst_d;
    logic              dren_q, dren_d;
    logic              dwen_q, dwen_d;
    logic              regwen_q, regwen_d;
    logic              memtoreg_q, memtoreg_d;
    logic              halt_q, halt_d;
    logic              capture;

    assign mem_stall = (state_q == StReq);
    // A latched halt blocks every further capture until reset.
    assign capture   = ihit & ~mem_stall & ~halt_q;

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        npc_d      = npc_q;
        alu_d      = alu_q;
        store_d    = store_q;
        load_d     = load_q;
        regdst_d   = regdst_q;
        dren_d     = dren_q;
        dwen_d     = dwen_q;
        regwen_d   = regwen_q;
        memtoreg_d = memtoreg_q;
        halt_d     = halt_q;

        if (state_q == StReq) begin
            if (dbus.dhit) begin
                if (dren_q && !dwen_q) begin
                    load_d = dbus.dmemload;
                end
                state_d = StDone;
            end
        end else if (capture) begin
            load_d = '0;
            if (flush) begin
                instr_d    = '0;
                npc_d      = '0;
                alu_d      = '0;
                store_d    = '0;
                regdst_d   = '0;
                dren_d     = 1'b0;
                dwen_d     = 1'b0;
                regwen_d   = 1'b0;
                memtoreg_d = 1'b0;
                halt_d     = 1'b0;
                state_d    = StIdle;
            end else begin
                instr_d    = instr_in;
                npc_d      = npc_in;
                alu_d      = alu_in;
                store_d    = store_in;
                regdst_d   = regdst_in;
                dren_d     = dREN_in;
                dwen_d     = dWEN_in;
                regwen_d   = regwen_in;
                memtoreg_d = memtoreg_in;
                halt_d     = halt_in;
                state_d    = (dREN_in || dWEN_in) ? StReq : StIdle;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= StIdle;
            instr_q    <= '0;
            npc_q      <= '0;
            alu_q      <= '0;
            store_q    <= '0;
            load_q     <= '0;
            regdst_q   <= '0;
            dren_q     <= 1'b0;
            dwen_q     <= 1'b0;
            regwen_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            npc_q      <= npc_d;
            alu_q      <= alu_d;
            store_q    <= store_d;
            load_q     <= load_d;
            regdst_q   <= regdst_d;
            dren_q     <= dren_d;
            dwen_q     <= dwen_d;
            regwen_q   <= regwen_d;
            memtoreg_q <= memtoreg_d;
            halt_q     <= halt_d;
        end
    end

    // When both load and store are latched, the write takes priority.
    assign dbus.dmemREN   = mem_stall & dren_q & ~dwen_q;
    assign dbus.dmemWEN   = mem_stall & dwen_q;
    assign dbus.dmemaddr  = alu_q;
    assign dbus.dmemstore = store_q;

    assign instr_out    = instr_q;
    assign npc_out      = npc_q;
    assign alu_out      = alu_q;
    assign dmemload_out = load_q;
    assign regdst_out   = regdst_q;
    assign regwen_out   = regwen_q;
    assign memtoreg_out = memtoreg_q;
    assign halt_out     = halt_q;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios then random traffic, all checked against a
// transaction-level model (latched fields plus one "access pending" flag).
module tb_ex_mem_stage;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    logic              CLK  = 1'b0;
    logic              nRST = 1'b1;
    logic              ihit, flush;
    logic [WORD_W-1:0] instr_in, npc_in, alu_in, store_in;
    logic              dREN_in, dWEN_in;
    logic [REG_W-1:0]  regdst_in;
    logic              regwen_in, memtoreg_in, halt_in;
    logic [WORD_W-1:0] instr_out, npc_out, alu_out, dmemload_out;
    logic [REG_W-1:0]  regdst_out;
    logic              regwen_out, memtoreg_out, halt_out, mem_stall;

    ex_mem_stage_if #(.WORD_W(WORD_W)) dbus ();

    ex_mem_stage #(.WORD_W(WORD_W), .REG_W(REG_W)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .ihit         (ihit),
        .flush        (flush),
        .instr_in     (instr_in),
        .npc_in       (npc_in),
        .alu_in       (alu_in),
        .store_in     (store_in),
        .dREN_in      (dREN_in),
        .dWEN_in      (dWEN_in),
        .regdst_in    (regdst_in),
        .regwen_in    (regwen_in),
        .memtoreg_in  (memtoreg_in),
        .halt_in      (halt_in),
        .dbus         (dbus.master),
        .instr_out    (instr_out),
        .npc_out      (npc_out),
        .alu_out      (alu_out),
        .dmemload_out (dmemload_out),
        .regdst_out   (regdst_out),
        .regwen_out   (regwen_out),
        .memtoreg_out (memtoreg_out),
        .halt_out     (halt_out),
        .mem_stall    (mem_stall)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [WORD_W-1:0] instr, npc, alu, store, load;
        logic [REG_W-1:0]  regdst;
        logic              ren, wen, regwen, memtoreg, halt;
    } fields_t;

    fields_t exp_f;
    bit      busy;
    int      n_checks = 0;
    int      n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_f = '0;
        busy  = 1'b0;
    endtask

    // One clock edge: a pending access retires on dhit, otherwise an unhalted ihit captures.
    task automatic model_edge();
        if (busy) begin
            if (dbus.dhit) begin
                if (exp_f.ren && !exp_f.wen) exp_f.load = dbus.dmemload;
                busy = 1'b0;
            end
        end else if (ihit && !exp_f.halt) begin
            if (flush) begin
                exp_f = '0;
            end else begin
                exp_f.instr    = instr_in;
                exp_f.npc      = npc_in;
                exp_f.alu      = alu_in;
                exp_f.store    = store_in;
                exp_f.load     = '0;
                exp_f.regdst   = regdst_in;
                exp_f.ren      = dREN_in;
                exp_f.wen      = dWEN_in;
                exp_f.regwen   = regwen_in;
                exp_f.memtoreg = memtoreg_in;
                exp_f.halt     = halt_in;
            end
            busy = exp_f.ren | exp_f.wen;
        end
    endtask

    task automatic check_all();
        check_eq("instr_out", instr_out, exp_f.instr);
        check_eq("npc_out", npc_out, exp_f.npc);
        check_eq("alu_out", alu_out, exp_f.alu);
        check_eq("dmemload_out", dmemload_out, exp_f.load);
        check_eq("regdst_out", 32'(regdst_out), 32'(exp_f.regdst));
        check_eq("regwen_out", 32'(regwen_out), 32'(exp_f.regwen));
        check_eq("memtoreg_out", 32'(memtoreg_out), 32'(exp_f.memtoreg));
        check_eq("halt_out", 32'(halt_out), 32'(exp_f.halt));
        check_eq("mem_stall", 32'(mem_stall), 32'(busy));
        check_eq("dmemREN", 32'(dbus.dmemREN), 32'(busy & exp_f.ren & ~exp_f.wen));
        check_eq("dmemWEN", 32'(dbus.dmemWEN), 32'(busy & exp_f.wen));
        check_eq("dmemaddr", dbus.dmemaddr, exp_f.alu);
        check_eq("dmemstore", dbus.dmemstore, exp_f.store);
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    // Pulse reset well away from clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #2 nRST = 1'b0;
        #1 model_reset();
        check_all();
        #2 nRST = 1'b1;
    endtask

    task automatic idle_inputs();
        ihit = 0; flush = 0; instr_in = '0; npc_in = '0; alu_in = '0; store_in = '0;
        dREN_in = 0; dWEN_in = 0; regdst_in = '0; regwen_in = 0; memtoreg_in = 0;
        halt_in = 0; dbus.dhit = 0; dbus.dmemload = '0;
    endtask

    task automatic drive_op(input logic [31:0] instr, input logic [31:0] alu,
                            input logic [31:0] store, input logic ren, input logic wen,
                            input logic halt);
        ihit = 1; instr_in = instr; npc_in = instr + 32'd4; alu_in = alu; store_in = store;
        dREN_in = ren; dWEN_in = wen; regdst_in = instr[4:0]; regwen_in = ~wen;
        memtoreg_in = ren; halt_in = halt;
    endtask

    initial begin
        idle_inputs();
        #1 nRST = 1'b0;
        #1 model_reset();
        check_all();
        #1 nRST = 1'b1;

        // ALU op
        drive_op(32'h0000_0020, 32'h1234, 32'h0, 0, 0, 0);
        cycle();
        check_eq("alu_op_result", alu_out, 32'h1234);
        ihit = 0;

        // Load with dhit on the third REQ cycle
        drive_op(32'h8c00_0001, 32'h100, 32'h0, 1, 0, 0);
        cycle();
        ihit = 0;
        for (int i = 0; i < 2; i++) begin
            check_eq("load_ren_held", 32'(dbus.dmemREN), 32'd1);
            check_eq("load_addr_held", dbus.dmemaddr, 32'h100);
            cycle();
        end
        check_eq("load_stall_dhit_cycle", 32'(mem_stall), 32'd1);
        dbus.dhit = 1; dbus.dmemload = 32'hDEAD_BEEF;
        cycle();
        dbus.dhit = 0;
        check_eq("load_data", dmemload_out, 32'hDEAD_BEEF);
        check_eq("load_ren_drop", 32'(dbus.dmemREN), 32'd0);

        // Store, dhit after two cycles
        drive_op(32'hac00_0002, 32'h200, 32'hCAFE, 0, 1, 0);
        cycle();
        ihit = 0;
        check_eq("store_wen", 32'(dbus.dmemWEN), 32'd1);
        check_eq("store_data", dbus.dmemstore, 32'hCAFE);
        cycle();
        dbus.dhit = 1; dbus.dmemload = 32'h5555_5555;
        cycle();
        dbus.dhit = 0;
        check_eq("store_no_load", dmemload_out, 32'h0);

        // Flush and a new instruction while a load is pending are ignored
        drive_op(32'h8c00_0003, 32'h300, 32'h0, 1, 0, 0);
        cycle();
        drive_op(32'h0000_0044, 32'h4444, 32'h0, 0, 0, 0);
        flush = 1;
        cycle();
        cycle();
        check_eq("req_ignores_new", instr_out, 32'h8c00_0003);
        flush = 0; dbus.dhit = 1; dbus.dmemload = 32'h0BAD_F00D;
        cycle();
        dbus.dhit = 0;
        cycle();
        check_eq("after_dhit_capture", instr_out, 32'h0000_0044);

        // Flush with ihit on a load gives a bubble
        drive_op(32'h8c00_0005, 32'h500, 32'h0, 1, 0, 0);
        flush = 1;
        cycle();
        flush = 0; ihit = 0;
        check_eq("bubble_instr", instr_out, 32'h0);
        check_eq("bubble_no_req", 32'(dbus.dmemREN), 32'd0);

        // Halt freezes outputs
        drive_op(32'hffff_ffff, 32'h77, 32'h0, 0, 0, 1);
        cycle();
        drive_op(32'h0000_0066, 32'h66, 32'h0, 1, 0, 0);
        cycle();
        cycle();
        check_eq("halt_held", 32'(halt_out), 32'd1);
        check_eq("halt_frozen", instr_out, 32'hffff_ffff);
        ihit = 0;
        async_reset();

        // Reset mid-REQ abandons the access
        drive_op(32'h8c00_0007, 32'h700, 32'h0, 1, 0, 0);
        cycle();
        ihit = 0;
        cycle();
        async_reset();
        check_eq("reset_ren", 32'(dbus.dmemREN), 32'd0);
        drive_op(32'h0000_0088, 32'h88, 32'h0, 0, 0, 0);
        cycle();
        check_eq("restart_alu", alu_out, 32'h88);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive_op($urandom, $urandom, $urandom, ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0));
            ihit          = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 7) == 0);
            regwen_in     = $urandom_range(0, 1);
            dbus.dhit     = ($urandom_range(0, 2) == 0);
            dbus.dmemload = $urandom;
            cycle();
            if ($urandom_range(0, 199) == 0 || (exp_f.halt && $urandom_range(0, 9) == 0)) begin
                async_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
